// File: rtl/numerical_integrator_pkg.sv
// rtl/numerical_integrator_pkg.sv - widths and signed clamp helpers for the trapezoidal integrator
package numerical_integrator_pkg;

    localparam int N     = 16;
    localparam int GUARD = 16;
    localparam int ACC_W = N + GUARD + 1;

    // Clamp a one-bit-wide accumulator sum back into ACC_W bits.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        logic signed [ACC_W-1:0] r;
        if (v[ACC_W] != v[ACC_W-1]) begin
            r = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [N-1:0] sat_n(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] n_max;
        logic signed [ACC_W-1:0] n_min;
        logic signed [N-1:0]     r;
        n_max = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
        n_min = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
        if (v > n_max) begin
            r = {1'b0, {(N-1){1'b1}}};
        end else if (v < n_min) begin
            r = {1'b1, {(N-1){1'b0}}};
        end else begin
            r = v[N-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/numerical_integrator_if.sv
// rtl/numerical_integrator_if.sv - sample/control/result bundle for the integrator
import numerical_integrator_pkg::*;

interface numerical_integrator_if;
    logic signed [N-1:0] signal_input;
    logic                start_integration;
    logic signed [N-1:0] integral_result;

    modport master (output signal_input, output start_integration, input integral_result);
    modport slave  (input signal_input, input start_integration, output integral_result);
endinterface

// File: rtl/numerical_integrator_sat_add.sv
// rtl/numerical_integrator_sat_add.sv - combinational saturating signed adder
module sat_add_signed #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [W:0] full;

    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        y    = full[W-1:0];
        // Two sign bits disagreeing means the true sum left the W-bit range.
        if (full[W] != full[W-1]) begin
            y = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/numerical_integrator.sv
// rtl/numerical_integrator.sv - trapezoidal integrator, half-LSB accumulator, saturated output
module numerical_integrator
    import numerical_integrator_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetb,
    numerical_integrator_if.slave bus
);

    logic signed [N-1:0]     x_prev_q, x_prev_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sample_sum;
    logic signed [ACC_W-1:0] acc_sum;

    // x[n] + x[n-1] is exactly twice the trapezoid area, so acc counts half-LSBs.
    assign sample_sum = {{(ACC_W-N){bus.signal_input[N-1]}}, bus.signal_input}
                      + {{(ACC_W-N){x_prev_q[N-1]}}, x_prev_q};

    sat_add_signed #(.W(ACC_W)) u_sat_add (
        .a (acc_q),
        .b (sample_sum),
        .y (acc_sum)
    );

    always_comb begin
        x_prev_d = bus.signal_input;
        acc_d    = '0;
        if (bus.start_integration) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            x_prev_q <= '0;
            acc_q    <= '0;
        end else begin
            x_prev_q <= x_prev_d;
            acc_q    <= acc_d;
        end
    end

    assign bus.integral_result = sat_n(acc_q >>> 1);

endmodule

// File: tb/tb_numerical_integrator.sv
// tb/tb_numerical_integrator.sv - directed bench with an integer trapezoid model
module tb_numerical_integrator;

    logic clk = 1'b0;
    logic resetb;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    longint acc_m = 0;
    longint xp_m  = 0;

    localparam longint ACC_MAX = 64'sd4294967295;
    localparam longint ACC_MIN = -64'sd4294967296;

    numerical_integrator_if bus ();

    numerical_integrator dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic longint model_result();
        longint q;
        q = acc_m / 2;
        if (acc_m < 0 && (acc_m % 2) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (longint'(bus.integral_result) != model_result()) begin
                failures++;
                $display("FAIL model_cmp t=%0t actual=%0d required=%0d", $time,
                         bus.integral_result, model_result());
            end
        end
    end

    task automatic step(input logic rb, input logic st, input int x);
        @(negedge clk);
        #1;
        resetb = rb;
        bus.start_integration = st;
        bus.signal_input = 16'(x);
        @(posedge clk);
        if (!rb) begin
            acc_m = 0;
            xp_m  = 0;
        end else if (!st) begin
            acc_m = 0;
            xp_m  = x;
        end else begin
            acc_m = acc_m + x + xp_m;
            if (acc_m > ACC_MAX) acc_m = ACC_MAX;
            if (acc_m < ACC_MIN) acc_m = ACC_MIN;
            xp_m = x;
        end
        chk_en = 1'b1;
        #1;
        bus.signal_input = 16'($urandom);
        bus.start_integration = 1'($urandom);
    endtask

    task automatic expect_val(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step_lit(input logic rb, input logic st, input int x, input int req);
        step(rb, st, x);
        expect_val("lit_result", longint'(bus.integral_result), longint'(req));
    endtask

    int ramp_in[7]  = '{2, 4, 6, 8, 10, 10, 10};
    int ramp_out[7] = '{6, 9, 14, 21, 30, 40, 50};
    longint prev_r;
    bit     descended;

    initial begin
        resetb = 1'b0;
        bus.start_integration = 1'b1;
        bus.signal_input = 16'sd10;

        for (int i = 0; i < 3; i++) step_lit(1'b0, 1'b1, 10, 0);
        expect_val("acc_after_reset", longint'(dut.acc_q), 0);

        for (int i = 1; i <= 5; i++) step_lit(1'b1, 1'b0, 2 * i, 0);
        expect_val("x_prev_tracks", longint'(dut.x_prev_q), 10);

        for (int i = 0; i < 7; i++) step_lit(1'b1, 1'b1, ramp_in[i], ramp_out[i]);

        step_lit(1'b1, 1'b0, 0, 0);
        step_lit(1'b1, 1'b1, 3, 1);
        expect_val("acc_half_pos", longint'(dut.acc_q), 3);
        step_lit(1'b1, 1'b1, 0, 3);
        step_lit(1'b1, 1'b0, 0, 0);
        step_lit(1'b1, 1'b1, -3, -2);
        expect_val("acc_half_neg", longint'(dut.acc_q), -3);
        step_lit(1'b1, 1'b1, 0, -3);

        step_lit(1'b1, 1'b0, 0, 0);
        step_lit(1'b1, 1'b1, 32767, 16383);
        step_lit(1'b1, 1'b1, 32767, 32767);
        for (int i = 0; i < 5; i++) step_lit(1'b1, 1'b1, 32767, 32767);

        prev_r = longint'(bus.integral_result);
        descended = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, -32768);
            checks++;
            if (longint'(bus.integral_result) > prev_r) begin
                failures++;
                $display("FAIL monotonic_down actual=%0d required<=%0d",
                         bus.integral_result, prev_r);
            end
            if (longint'(bus.integral_result) < prev_r) descended = 1'b1;
            prev_r = longint'(bus.integral_result);
        end
        expect_val("descended", longint'(descended), 1);
        expect_val("neg_clamp", longint'(bus.integral_result), -32768);

        step_lit(1'b1, 1'b0, 5, 0);
        step_lit(1'b1, 1'b1, 5, 5);
        step_lit(1'b1, 1'b1, 7, 11);
        step_lit(1'b1, 1'b0, 7, 0);
        step_lit(1'b1, 1'b1, 1, 4);
        step_lit(1'b0, 1'b1, 9, 0);
        expect_val("x_prev_reset", longint'(dut.x_prev_q), 0);
        step_lit(1'b1, 1'b1, 2, 1);

        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
